// File: rtl/inst_fetch_queue_pkg.sv
// Shared constants and types for the instruction fetch queue.
// Holds the fetch-entry layout and the PC alignment helper.
package inst_fetch_queue_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] INST_NOP = 32'h0000_0013;
  localparam logic [XLEN-1:0] PC_STRIDE = 32'd4;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
    return pc & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/inst_fetch_queue_if.sv
// Bundle of the fetch stage's memory-side and decode-side signals.
// master = fetch stage, slave = memory/decode environment.
interface inst_fetch_queue_if;
  import inst_fetch_queue_pkg::*;

  logic            mem_req;
  logic [XLEN-1:0] mem_addr;
  logic            mem_gnt;
  logic            mem_rvalid;
  logic [XLEN-1:0] mem_rdata;
  logic            redirect;
  logic [XLEN-1:0] redirect_pc;
  logic            inst_valid;
  logic [XLEN-1:0] inst;
  logic [XLEN-1:0] inst_pc;
  logic            inst_ready;

  modport master (
    output mem_req, mem_addr,
    input  mem_gnt, mem_rvalid, mem_rdata,
    input  redirect, redirect_pc,
    output inst_valid, inst, inst_pc,
    input  inst_ready
  );

  modport slave (
    input  mem_req, mem_addr,
    output mem_gnt, mem_rvalid, mem_rdata,
    output redirect, redirect_pc,
    input  inst_valid, inst, inst_pc,
    output inst_ready
  );

endinterface

// File: rtl/inst_fetch_queue_fifo.sv
// Synchronous {pc,inst} FIFO with flush and registered head outputs.
// Head registers are loaded from next-state, so a push shows up one cycle later.
module inst_fetch_queue_fifo
  import inst_fetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PtrW = $clog2(DEPTH),
  localparam int unsigned CntW = PtrW + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_push,
  input  fetch_entry_t    i_wdata,
  input  logic            i_pop,
  input  logic            i_flush,
  output logic [CntW-1:0] o_count,
  output logic            o_valid,
  output fetch_entry_t    o_head
);

  fetch_entry_t    r_mem [DEPTH];
  logic [PtrW-1:0] r_rd_ptr, r_wr_ptr;
  logic [PtrW-1:0] w_rd_ptr_d, w_wr_ptr_d;
  logic [CntW-1:0] r_count, w_count_d, w_count_rem;
  logic            r_valid, w_valid_d;
  fetch_entry_t    r_head, w_head_d;

  always_comb begin
    w_count_rem = r_count - CntW'(i_pop);
    w_count_d   = w_count_rem + CntW'(i_push);
    w_rd_ptr_d  = r_rd_ptr + PtrW'(i_pop);
    w_wr_ptr_d  = r_wr_ptr + PtrW'(i_push);
    w_valid_d   = 1'b0;
    w_head_d    = '{pc: '0, inst: INST_NOP};
    if (i_flush) begin
      w_count_d  = '0;
      w_rd_ptr_d = '0;
      w_wr_ptr_d = '0;
    end else if (w_count_d != '0) begin
      w_valid_d = 1'b1;
      // An empty queue (after any pop) means the new head is the word arriving now.
      w_head_d  = (w_count_rem == '0) ? i_wdata : r_mem[w_rd_ptr_d];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count  <= '0;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_valid  <= 1'b0;
      r_head   <= '{pc: '0, inst: INST_NOP};
    end else begin
      r_count  <= w_count_d;
      r_rd_ptr <= w_rd_ptr_d;
      r_wr_ptr <= w_wr_ptr_d;
      r_valid  <= w_valid_d;
      r_head   <= w_head_d;
    end
  end

  always_ff @(posedge clk) begin
    if (i_push && !i_flush) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  assign o_count = r_count;
  assign o_valid = r_valid;
  assign o_head  = r_head;

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    (i_push && !i_pop && !i_flush) |-> (r_count != CntW'(DEPTH)));

endmodule

// File: rtl/inst_fetch_queue.sv
// Fetch stage: issues word fetches under a credit limit, drops stale responses
// after a redirect and buffers returned words for decode.
module inst_fetch_queue
  import inst_fetch_queue_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned     DEPTH    = 4
) (
  input logic               clk,
  input logic               rst,
  inst_fetch_queue_if.master bus
);

  localparam int unsigned CntW = $clog2(DEPTH) + 1;
  localparam logic [CntW:0] DepthLim = (CntW + 1)'(DEPTH);

  logic [XLEN-1:0] r_fetch_pc, r_resp_pc;
  logic [CntW-1:0] r_outstanding, r_drop;
  logic [CntW-1:0] w_out_d, w_count;
  logic [CntW:0]   w_inflight;
  logic            w_req, w_gnt_fire, w_rvalid, w_redirect;
  logic            w_drop_word, w_push, w_pop, w_head_valid;
  fetch_entry_t    w_wdata, w_head;

  // Buffered plus in-flight words never exceed DEPTH, so a response always has a slot.
  assign w_inflight   = {1'b0, w_count} + {1'b0, r_outstanding};
  assign w_redirect   = bus.redirect & ~rst;
  assign w_req        = ~rst & ~bus.redirect & (w_inflight < DepthLim);
  assign w_gnt_fire   = w_req & bus.mem_gnt;
  assign w_rvalid     = bus.mem_rvalid & ~rst;
  assign w_drop_word  = (r_drop != '0);
  assign w_push       = w_rvalid & ~w_redirect & ~w_drop_word;
  assign w_pop        = w_head_valid & bus.inst_ready & ~w_redirect;
  assign w_out_d      = r_outstanding + CntW'(w_gnt_fire) - CntW'(w_rvalid);
  assign w_wdata      = '{pc: r_resp_pc, inst: bus.mem_rdata};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_pc    <= align_pc(RESET_PC);
      r_resp_pc     <= align_pc(RESET_PC);
      r_outstanding <= '0;
      r_drop        <= '0;
    end else begin
      r_outstanding <= w_out_d;
      if (w_redirect) begin
        r_fetch_pc <= align_pc(bus.redirect_pc);
        r_resp_pc  <= align_pc(bus.redirect_pc);
        // Every word still owed by memory belongs to the abandoned stream.
        r_drop     <= w_out_d;
      end else begin
        if (w_gnt_fire) begin
          r_fetch_pc <= r_fetch_pc + PC_STRIDE;
        end
        if (w_rvalid) begin
          if (w_drop_word) begin
            r_drop <= r_drop - CntW'(1);
          end else begin
            r_resp_pc <= r_resp_pc + PC_STRIDE;
          end
        end
      end
    end
  end

  inst_fetch_queue_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_wdata (w_wdata),
    .i_pop   (w_pop),
    .i_flush (w_redirect),
    .o_count (w_count),
    .o_valid (w_head_valid),
    .o_head  (w_head)
  );

  assign bus.mem_req    = w_req;
  assign bus.mem_addr   = r_fetch_pc;
  assign bus.inst_valid = w_head_valid;
  assign bus.inst       = w_head.inst;
  assign bus.inst_pc    = w_head.pc;

endmodule
